// File: rtl/vga_sync_rx.sv
// vga_sync_rx
// VGA timing receiver. Recovers the pixel/line position from an incoming
// hsync/vsync pair (same clk domain as the generator), measures line and
// frame periods, declares lock once the timing matches nominal, and
// regenerates pixel_x/pixel_y/video_on for downstream capture logic.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset (0 = reset asserted)
//   p_tick       pixel enable; all counting and edge sampling qualified by it
//   hsync_in     horizontal sync, active-high
//   vsync_in     vertical sync, active-high
//   pixel_x      recovered horizontal position
//   pixel_y      recovered vertical position
//   video_on     locked && pixel_x < HD && pixel_y < VD
//   locked       timing lock indicator
//   frame_start  one-clk pulse on each vsync leading edge
//   line_len     last measured hsync-to-hsync period in ticks (saturating)
//   timing_err   one-clk pulse when lock is broken
module vga_sync_rx #(
   parameter int HD           = 640,
   parameter int VD           = 480,
   parameter int H_TOTAL      = 800,
   parameter int V_TOTAL      = 525,
   parameter int H_SYNC_START = 656,
   parameter int V_SYNC_START = 490,
   parameter int SYNC_LAT     = 1,
   parameter int LOCK_LINES   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p_tick,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [9:0]  pixel_x,
   output logic [9:0]  pixel_y,
   output logic        video_on,
   output logic        locked,
   output logic        frame_start,
   output logic [10:0] line_len,
   output logic        timing_err
);

   // The detected hsync edge lags the source count by SYNC_LAT ticks, so the
   // reload value is advanced by the same amount to stay in step.
   localparam logic [9:0]  H_LOAD       = 10'((H_SYNC_START + SYNC_LAT) % H_TOTAL);
   localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_LOAD       = 10'(V_SYNC_START);
   localparam logic [9:0]  H_ACTIVE     = 10'(HD);
   localparam logic [9:0]  V_ACTIVE     = 10'(VD);
   localparam logic [10:0] H_PERIOD     = 11'(H_TOTAL);
   localparam logic [10:0] TIMEOUT_LAST = 11'(2 * H_TOTAL - 1);
   localparam logic [10:0] PERIOD_MAX   = 11'h7FF;
   localparam logic [9:0]  FRAME_LINES  = 10'(V_TOTAL);
   localparam logic [9:0]  FRAME_MAX    = 10'h3FF;
   localparam logic [7:0]  RUN_LAST     = 8'(LOCK_LINES - 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      H_OK   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t      state;
   state_t      next_state;

   logic        hs_prev;
   logic        vs_prev;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic [10:0] period_cnt;
   logic [10:0] period_next;
   logic        meas_valid;
   logic [9:0]  frame_lines;
   logic        frame_armed;
   logic        armed_next;
   logic [7:0]  good_run;
   logic [7:0]  run_next;
   logic        err_event;
   logic        search_entry;

   logic        h_edge;
   logic        v_edge;
   logic        h_wrap;
   logic        meas_edge;
   logic        good_line;
   logic        timeout;
   logic        bad_line;
   logic        frame_ok;

   // Edge and event decode; everything is gated by p_tick so nothing can be
   // seen between pixel ticks.
   always_comb begin
      h_edge      = p_tick & hsync_in & ~hs_prev;
      v_edge      = p_tick & vsync_in & ~vs_prev;
      h_wrap      = p_tick & ~h_edge & (h_cnt == H_LAST);
      period_next = (period_cnt == PERIOD_MAX) ? PERIOD_MAX : period_cnt + 11'd1;
      meas_edge   = h_edge & meas_valid;
      good_line   = meas_edge & (period_next == H_PERIOD);
      timeout     = p_tick & ~h_edge & (period_cnt == TIMEOUT_LAST);
      bad_line    = (meas_edge & ~good_line) | timeout;
      frame_ok    = (frame_lines == FRAME_LINES);
   end

   // Lock FSM next-state logic. Falling back to SEARCH always discards the
   // good-line run and the frame arm flag, whatever state it came from.
   always_comb begin
      next_state = state;
      run_next   = good_run;
      armed_next = frame_armed;
      err_event  = 1'b0;
      case (state)
         SEARCH: begin
            if (bad_line) begin
               run_next = 8'd0;
            end else if (good_line) begin
               if (good_run >= RUN_LAST) begin
                  next_state = H_OK;
                  run_next   = 8'd0;
               end else begin
                  run_next = good_run + 8'd1;
               end
            end
         end
         H_OK: begin
            if (bad_line) begin
               next_state = SEARCH;
            end else if (v_edge) begin
               if (!frame_armed) begin
                  armed_next = 1'b1;
               end else if (frame_ok) begin
                  next_state = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (bad_line || (v_edge && !frame_ok)) begin
               next_state = SEARCH;
               err_event  = 1'b1;
            end
         end
         default: begin
            next_state = SEARCH;
         end
      endcase
      search_entry = (next_state == SEARCH) && (state != SEARCH);
      if (search_entry) begin
         run_next   = 8'd0;
         armed_next = 1'b0;
      end
   end

   // Lock FSM state register and its registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= SEARCH;
         good_run    <= 8'd0;
         frame_armed <= 1'b0;
         locked      <= 1'b0;
         timing_err  <= 1'b0;
      end else begin
         state       <= next_state;
         good_run    <= run_next;
         frame_armed <= armed_next;
         locked      <= (next_state == LOCKED);
         timing_err  <= err_event;
      end
   end

   // Position counters, sync edge registers and period measurement.
   // A sync load takes precedence over the normal increment/wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hs_prev     <= 1'b0;
         vs_prev     <= 1'b0;
         h_cnt       <= 10'd0;
         v_cnt       <= 10'd0;
         period_cnt  <= 11'd0;
         meas_valid  <= 1'b0;
         line_len    <= 11'd0;
         frame_lines <= 10'd0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= v_edge;
         if (p_tick) begin
            hs_prev <= hsync_in;
            vs_prev <= vsync_in;
         end

         if (h_edge) begin
            h_cnt <= H_LOAD;
         end else if (p_tick) begin
            h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
         end

         if (v_edge) begin
            v_cnt <= V_LOAD;
         end else if (h_wrap) begin
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
         end

         if (h_edge || timeout) begin
            period_cnt <= 11'd0;
         end else if (p_tick) begin
            period_cnt <= period_next;
         end

         if (meas_edge) begin
            line_len <= period_next;
         end

         // The first hsync after reset, a timeout or a fall back to SEARCH
         // only opens a measurement window; it does not report a period.
         if (search_entry || timeout) begin
            meas_valid <= 1'b0;
         end else if (h_edge) begin
            meas_valid <= 1'b1;
         end

         if (v_edge) begin
            frame_lines <= h_edge ? 10'd1 : 10'd0;
         end else if (h_edge && frame_lines != FRAME_MAX) begin
            frame_lines <= frame_lines + 10'd1;
         end
      end
   end

   assign pixel_x  = h_cnt;
   assign pixel_y  = v_cnt;
   assign video_on = locked && (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx
// Directed testbench for vga_sync_rx. A behavioural sync generator with a
// reduced raster (40x12 ticks) drives the receiver with p_tick every second
// clk; expected positions, periods and lock behaviour come from that model
// and from hand-computed tick counts.
module tb_vga_sync_rx;

   localparam int HD    = 32;
   localparam int VD    = 8;
   localparam int HT    = 40;
   localparam int VT    = 12;
   localparam int HSS   = 34;
   localparam int HSW   = 4;
   localparam int VSS   = 9;
   localparam int VSW   = 2;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        reset;
   logic        p_tick;
   logic        hsync_in;
   logic        vsync_in;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        video_on;
   logic        locked;
   logic        frame_start;
   logic [10:0] line_len;
   logic        timing_err;

   int total_cnt = 0;
   int pass_cnt  = 0;
   int fail_cnt  = 0;

   int gh = 0;
   int gv = 0;
   bit short_line  = 1'b0;
   bit short_frame = 1'b0;
   bit hold_hs     = 1'b0;

   int   xy_bad;
   int   vid_bad;
   int   err_seen;
   int   fs_seen;
   logic te_now   = 1'b0;
   logic fs_now   = 1'b0;
   logic te_after = 1'b0;

   always #5 clk = ~clk;

   vga_sync_rx #(
      .HD(HD), .VD(VD), .H_TOTAL(HT), .V_TOTAL(VT),
      .H_SYNC_START(HSS), .V_SYNC_START(VSS), .SYNC_LAT(1), .LOCK_LINES(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .p_tick(p_tick),
      .hsync_in(hsync_in),
      .vsync_in(vsync_in),
      .pixel_x(pixel_x),
      .pixel_y(pixel_y),
      .video_on(video_on),
      .locked(locked),
      .frame_start(frame_start),
      .line_len(line_len),
      .timing_err(timing_err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input int expv);
      total_cnt++;
      assert (obs === 32'(expv)) pass_cnt++;
      else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One pixel tick: drive syncs from the generator count, pulse p_tick for
   // one clk, sample registered pulses, advance the generator, then idle one clk.
   task automatic applyStimulus();
      hsync_in = (!hold_hs && gh >= HSS && gh < HSS + HSW);
      vsync_in = (gv >= VSS && gv < VSS + VSW);
      p_tick   = 1'b1;
      @(posedge clk);
      #1;
      p_tick = 1'b0;
      te_now = timing_err;
      fs_now = frame_start;
      if (te_now) err_seen++;
      if (fs_now) fs_seen++;
      if (gh == HT - 1 || (short_line && gh == HT - 2)) begin
         short_line = 1'b0;
         gh = 0;
         if (gv == VT - 1 || (short_frame && gv == VT - 2)) begin
            short_frame = 1'b0;
            gv = 0;
         end else begin
            gv++;
         end
      end else begin
         gh++;
      end
      if (pixel_x !== 10'(gh) || pixel_y !== 10'(gv)) xy_bad++;
      if (video_on !== (gh < HD && gv < VD)) vid_bad++;
      @(posedge clk);
      #1;
      te_after = timing_err;
   endtask

   task automatic waitLock(input string tag);
      int n;
      n = 0;
      while (locked !== 1'b1 && n < 4 * FRAME) begin
         applyStimulus();
         n++;
      end
      checkOutput(tag, 32'(locked), 1);
   endtask

   initial begin
      int n;
      int fsc;

      // Reset state
      reset    = 1'b0;
      p_tick   = 1'b0;
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_pixel_x", 32'(pixel_x), 0);
      checkOutput("rst_pixel_y", 32'(pixel_y), 0);
      checkOutput("rst_locked", 32'(locked), 0);
      checkOutput("rst_video_on", 32'(video_on), 0);
      checkOutput("rst_line_len", 32'(line_len), 0);
      reset = 1'b1;

      // Initial acquisition: 4 good lines then two v_edges one frame apart
      n = 0;
      while (locked !== 1'b1 && n < 2 * FRAME) begin
         applyStimulus();
         n++;
      end
      checkOutput("lock_within_2_frames", 32'(locked), 1);

      // Three clean frames while locked
      xy_bad = 0; vid_bad = 0; err_seen = 0; fs_seen = 0;
      repeat (3 * FRAME) applyStimulus();
      checkOutput("xy_tracks_generator", 32'(xy_bad), 0);
      checkOutput("video_on_matches", 32'(vid_bad), 0);
      checkOutput("no_timing_err", 32'(err_seen), 0);
      checkOutput("frame_start_count", 32'(fs_seen), 3);
      checkOutput("line_len_nominal", 32'(line_len), HT);
      checkOutput("still_locked", 32'(locked), 1);

      // One line shortened to HT-1 ticks
      while (!(gv == 2 && gh == 0)) applyStimulus();
      short_line = 1'b1;
      n = 0;
      te_now = 1'b0;
      while (!te_now && n < 3 * HT) begin
         applyStimulus();
         n++;
      end
      checkOutput("short_err_pulse", 32'(te_now), 1);
      checkOutput("short_err_tick", n, 74);
      checkOutput("short_line_len", 32'(line_len), HT - 1);
      checkOutput("short_locked", 32'(locked), 0);
      checkOutput("short_video_on", 32'(video_on), 0);
      checkOutput("short_err_width", 32'(te_after), 0);
      waitLock("relock_short_line");

      // hsync held low: timeout 2*HT ticks after the last h_edge
      while (!(gv == 2 && gh == HSS + 1)) applyStimulus();
      hold_hs = 1'b1;
      n = 0;
      te_now = 1'b0;
      while (!te_now && n < 4 * HT) begin
         applyStimulus();
         n++;
      end
      checkOutput("timeout_tick", n, 2 * HT);
      checkOutput("timeout_locked", 32'(locked), 0);
      while (gh != 0) applyStimulus();
      hold_hs = 1'b0;
      waitLock("relock_timeout");

      // One frame of VT-1 lines
      while (!(gv == VT - 2 && gh == 0)) applyStimulus();
      short_frame = 1'b1;
      n = 0;
      te_now = 1'b0;
      while (!te_now && n < 2 * FRAME) begin
         applyStimulus();
         n++;
      end
      checkOutput("short_frame_err", 32'(te_now), 1);
      checkOutput("short_frame_fs", 32'(fs_now), 1);
      checkOutput("short_frame_locked", 32'(locked), 0);
      checkOutput("short_frame_vload", 32'(pixel_y), VSS);
      waitLock("relock_short_frame");

      // Asynchronous reset mid-line
      while (!(gv == 3 && gh == 20)) applyStimulus();
      checkOutput("pre_reset_x", 32'(pixel_x), 20);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_rst_x", 32'(pixel_x), 0);
      checkOutput("async_rst_y", 32'(pixel_y), 0);
      checkOutput("async_rst_locked", 32'(locked), 0);
      checkOutput("async_rst_video", 32'(video_on), 0);
      checkOutput("async_rst_line_len", 32'(line_len), 0);
      #2;
      reset = 1'b1;
      waitLock("relock_reset");
      xy_bad = 0;
      repeat (FRAME) applyStimulus();
      checkOutput("xy_after_relock", 32'(xy_bad), 0);

      // p_tick held low with syncs toggling
      fsc = 0;
      p_tick = 1'b0;
      repeat (100) begin
         hsync_in = ~hsync_in;
         vsync_in = ~vsync_in;
         @(posedge clk);
         #1;
         if (frame_start) fsc++;
      end
      checkOutput("hold_pixel_x", 32'(pixel_x), gh);
      checkOutput("hold_pixel_y", 32'(pixel_y), gv);
      checkOutput("hold_line_len", 32'(line_len), HT);
      checkOutput("hold_locked", 32'(locked), 1);
      checkOutput("hold_no_frame_start", fsc, 0);
      err_seen = 0;
      repeat (2 * HT) applyStimulus();
      checkOutput("post_hold_no_err", 32'(err_seen), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
VGA timing receiver. Recovers the pixel/line position from an incoming hsync/vsync pair produced by the team's 640x480 sync generator, all in the same clk domain. Measures line and frame periods, declares lock once timing matches nominal, and regenerates pixel_x/pixel_y/video_on for downstream capture or checking logic. Sits on the monitor/capture side, downstream of the sync generator or a loopback of its pins.

Parameters:
HD, 640, active pixels per line
VD, 480, active lines per frame
H_TOTAL, 800, pixel ticks per line
V_TOTAL, 525, lines per frame
H_SYNC_START, 656, h count at which source asserts hsync
V_SYNC_START, 490, v count at which source asserts vsync
SYNC_LAT, 1, pixel ticks between source count and detected sync edge; added to H_SYNC_START on load
LOCK_LINES, 4, consecutive correct line periods needed to leave SEARCH

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
p_tick  in  1  pixel enable; all counting and edge sampling are qualified by it
hsync_in  in  1  horizontal sync, active-high
vsync_in  in  1  vertical sync, active-high
pixel_x  out  10  recovered horizontal position
pixel_y  out  10  recovered vertical position
video_on  out  1  locked && pixel_x<HD && pixel_y<VD
locked  out  1  timing lock indicator
frame_start  out  1  one-clk pulse on each vsync leading edge
line_len  out  11  last measured hsync-to-hsync period in ticks, saturating at 2047
timing_err  out  1  one-clk pulse when a lock-breaking event occurs while locked

Behaviour:
- Reset (reset=0, asynchronous): every counter and register cleared; all outputs 0; FSM = SEARCH. Release takes effect on the next clk edge.
- Edge detect: hs_prev/vs_prev are updated only on p_tick.
  - h_edge = p_tick & hsync_in & ~hs_prev.
  - v_edge = p_tick & vsync_in & ~vs_prev.
  - Edges are evaluated once per pixel tick, never between ticks.
- h_cnt (10 bit): on p_tick, increments; wraps H_TOTAL-1 -> 0. On h_edge, loads (H_SYNC_START+SYNC_LAT) mod H_TOTAL. The load overrides increment/wrap in the same tick.
- v_cnt (10 bit): increments on the p_tick where h_cnt wraps; wraps V_TOTAL-1 -> 0. On v_edge, loads V_SYNC_START. The load wins over a simultaneous increment; h_cnt is untouched by v_edge.
- pixel_x = h_cnt, pixel_y = v_cnt, both registered. Zero latency relative to the counters.
- Line period counter:
  - Counts p_ticks since the last h_edge.
  - On h_edge: line_len <= count+1 (saturating at 2047); count clears.
  - good_line = (measured period == H_TOTAL).
  - The first h_edge after reset or SEARCH entry only starts the measurement.
- Frame line counter: counts h_edges since the last v_edge; on v_edge it is compared to V_TOTAL, then cleared. The first v_edge after entering H_OK only arms the comparison.
- Timeout: if the period counter reaches 2*H_TOTAL with no h_edge, the block treats it as a bad line.
- FSM:
  - SEARCH: count consecutive good lines; at LOCK_LINES -> H_OK. A bad line resets the run count.
  - H_OK: bad line/timeout -> SEARCH. On an armed v_edge, frame count == V_TOTAL -> LOCKED; otherwise stay and re-arm.
  - LOCKED: bad line, timeout, or frame count != V_TOTAL at v_edge -> SEARCH, with timing_err pulsed for 1 clk.
- locked = (state == LOCKED), registered; it drops on the clk edge following the error detection.
- frame_start pulses on every v_edge regardless of state.
- p_tick low: all counters, edge registers and the FSM hold. No edge can be detected.
- SEARCH entry clears the good-line run and the frame arm flag; h_cnt/v_cnt keep free-running and reloading.

Test Plan:
- Drive from the sync generator (p_tick every 2nd clk, SYNC_LAT=1) -> locked=1 within 2 frames of reset release; thereafter pixel_x/pixel_y equal the generator's counts at every p_tick, video_on matches the generator's, line_len=800, no timing_err for 3 frames.
- While locked, shorten one line to 799 ticks -> at that h_edge line_len=799, timing_err pulses 1 clk, locked=0, video_on=0; relock after 4 good lines plus 2 v_edges 525 lines apart.
- While locked, hold hsync_in low -> 1600 ticks after the last h_edge, timing_err pulses, locked=0, state SEARCH.
- While locked, deliver one frame of 524 lines -> at that v_edge timing_err=1, locked=0, frame_start=1 in the same cycle.
- Assert reset=0 mid-line at pixel_x=300 -> all outputs 0 immediately (before the next clk edge); after release, lock is reacquired.
- Hold p_tick=0 for 100 clks with syncs toggling -> pixel_x, pixel_y, line_len and locked unchanged; no frame_start.
